// File: rtl/branch_pkg.sv
// Shared branch-unit definitions: B-type condition codes and the redirect FSM state type.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {RUN, FLUSH} br_state_e;

endpackage

// File: rtl/branch_cond_decode.sv
// Maps funct3 plus comparator flags to a taken decision; 010/011 are reserved encodings.
module branch_cond_decode
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       br_less,
  input  logic       br_equal,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = br_equal;
      F3_BNE:  taken = ~br_equal;
      F3_BLT:  taken = br_less;
      F3_BGE:  taken = ~br_less;
      F3_BLTU: taken = br_less;
      F3_BGEU: taken = ~br_less;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch resolution: registered PC redirect, front-end flush window, branch statistics.
module branch_redirect_ctrl
  import branch_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             stall,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic             br_less,
  input  logic             br_equal,
  output logic             br_unsigned,
  output logic             pc_sel,
  output logic [WIDTH-1:0] pc_target,
  output logic             flush,
  output logic             illegal_br,
  output logic             misaligned,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  br_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic             dec_taken, dec_illegal;
  logic             jump, evaluate, redirect;
  logic [WIDTH-1:0] pc_sum, jalr_sum, target_raw, target;

  assign br_unsigned = funct3[1];

  branch_cond_decode u_dec (
    .funct3   (funct3),
    .br_less  (br_less),
    .br_equal (br_equal),
    .taken    (dec_taken),
    .illegal  (dec_illegal)
  );

  assign jump     = is_jal | is_jalr;
  assign evaluate = ex_valid & ~stall & (state_q == RUN) & (is_branch | jump);
  assign redirect = evaluate & (jump | (is_branch & dec_taken));

  // JALR clears bit 0 of its sum; bit 1 is left alone so misalignment stays visible.
  assign pc_sum     = pc + imm;
  assign jalr_sum   = rs1_data + imm;
  assign target_raw = is_jalr ? jalr_sum : pc_sum;
  assign target     = {target_raw[WIDTH-1:1], target_raw[0] & ~is_jalr};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush   = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_INIT;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (!stall) begin
          if (cnt_q == 3'd0) state_d = RUN;
          else               cnt_d   = cnt_q - 3'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Pulses re-evaluate every cycle; pc_target holds its last redirect value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_sel     <= 1'b0;
      pc_target  <= '0;
      illegal_br <= 1'b0;
      misaligned <= 1'b0;
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else begin
      pc_sel     <= redirect;
      illegal_br <= evaluate & is_branch & ~jump & dec_illegal;
      misaligned <= redirect & (target[1:0] != 2'b00);
      if (redirect) pc_target <= target;
      if (evaluate && branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
      if (redirect && taken_cnt != '1)  taken_cnt  <= taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: vector table with a scoreboard queue, then stall/reset/saturation sequences.
module tb_branch_redirect_ctrl;
  localparam int W  = 32;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n, ex_valid, stall, is_branch, is_jal, is_jalr, br_less, br_equal;
  logic [2:0] funct3;
  logic [W-1:0] pc, imm, rs1_data, pc_target;
  logic br_unsigned, pc_sel, flush, illegal_br, misaligned;
  logic [CW-1:0] branch_cnt, taken_cnt;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.WIDTH(W), .FLUSH_CYCLES(2), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .stall(stall),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3),
    .pc(pc), .imm(imm), .rs1_data(rs1_data), .br_less(br_less), .br_equal(br_equal),
    .br_unsigned(br_unsigned), .pc_sel(pc_sel), .pc_target(pc_target), .flush(flush),
    .illegal_br(illegal_br), .misaligned(misaligned),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  typedef struct {
    logic br, jal, jalr;
    logic [2:0] f3;
    logic [W-1:0] pc, imm, rs1;
    logic less, eq;
    logic exp_uns, exp_sel;
    logic [W-1:0] exp_tgt;
    logic exp_ill, exp_mis;
  } vec_t;

  typedef struct {
    logic sel;
    logic [W-1:0] tgt;
    logic ill, mis;
  } sb_t;

  vec_t vecs[12];
  sb_t  sbq[$];
  int checks = 0;
  int errors = 0;
  int exp_bc = 0;
  int exp_tc = 0;
  logic [W-1:0] last_tgt = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    is_branch = v.br; is_jal = v.jal; is_jalr = v.jalr; funct3 = v.f3;
    pc = v.pc; imm = v.imm; rs1_data = v.rs1; br_less = v.less; br_equal = v.eq;
  endtask

  task automatic wait_flush_clear();
    int n = 0;
    while (flush && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (flush) begin
      checks++;
      errors++;
      $display("FAIL flush_timeout: flush still %0b after %0d cycles", flush, n);
    end
  endtask

  task automatic chk_counts(input string name);
    chk({name, "_bcnt"}, W'(branch_cnt), W'(exp_bc));
    chk({name, "_tcnt"}, W'(taken_cnt), W'(exp_tc));
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Single taken JAL, waited out to RUN again.
  task automatic do_jal(input logic [W-1:0] p, input logic [W-1:0] o);
    vec_t v;
    v = '{1'b0, 1'b1, 1'b0, 3'b000, p, o, '0, 1'b0, 1'b0, 1'b0, 1'b1, p + o, 1'b0, 1'b0};
    @(negedge clk);
    drive(v);
    ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    exp_bc = sat(exp_bc + 1);
    exp_tc = sat(exp_tc + 1);
    wait_flush_clear();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    sb_t  s;
    int   fcount;

    //        br   jal  jalr f3      pc            imm           rs1           less eq   uns  sel  tgt           ill  mis
    vecs[0]  = '{1'b1,1'b0,1'b0,3'b000,32'h0000_0100,32'h0000_0020,32'h0,       1'b0,1'b1,1'b0,1'b1,32'h0000_0120,1'b0,1'b0};
    vecs[1]  = '{1'b1,1'b0,1'b0,3'b110,32'h0000_0100,32'h0000_0040,32'h0,       1'b0,1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b1,3'b000,32'h0000_0080,32'h0000_0000,32'h0000_0203,1'b0,1'b0,1'b0,1'b1,32'h0000_0202,1'b0,1'b1};
    vecs[3]  = '{1'b1,1'b0,1'b0,3'b001,32'h0000_1000,32'hFFFF_FFF0,32'h0,       1'b0,1'b0,1'b0,1'b1,32'h0000_0FF0,1'b0,1'b0};
    vecs[4]  = '{1'b1,1'b0,1'b0,3'b010,32'h0000_0200,32'h0000_0010,32'h0,       1'b1,1'b1,1'b1,1'b0,32'h0,        1'b1,1'b0};
    vecs[5]  = '{1'b1,1'b0,1'b0,3'b100,32'h0000_0200,32'h0000_0006,32'h0,       1'b1,1'b0,1'b0,1'b1,32'h0000_0206,1'b0,1'b1};
    vecs[6]  = '{1'b1,1'b0,1'b0,3'b101,32'h0000_0200,32'h0000_0010,32'h0,       1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0};
    vecs[7]  = '{1'b1,1'b0,1'b0,3'b111,32'hFFFF_FFFC,32'h0000_0008,32'h0,       1'b0,1'b0,1'b1,1'b1,32'h0000_0004,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b1,1'b0,3'b000,32'h0000_0040,32'h0000_0100,32'h0,       1'b0,1'b0,1'b0,1'b1,32'h0000_0140,1'b0,1'b0};
    vecs[9]  = '{1'b1,1'b0,1'b0,3'b000,32'h0000_0300,32'h0000_0010,32'h0,       1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0};
    vecs[10] = '{1'b1,1'b0,1'b0,3'b011,32'h0000_0300,32'h0000_0010,32'h0,       1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b1,3'b000,32'h0000_0000,32'h0000_0010,32'h0000_1001,1'b0,1'b0,1'b0,1'b1,32'h0000_1010,1'b0,1'b0};

    rst_n = 1'b0; ex_valid = 1'b0; stall = 1'b0;
    drive(vecs[9]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc_sel", W'(pc_sel), 0);
    chk("rst_flush", W'(flush), 0);
    chk("rst_pc_target", pc_target, 0);
    chk("rst_illegal", W'(illegal_br), 0);
    chk("rst_misaligned", W'(misaligned), 0);
    chk_counts("rst");
    rst_n = 1'b1;

    // Table vectors through the scoreboard queue.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      ex_valid = 1'b1;
      sbq.push_back('{vecs[i].exp_sel, vecs[i].exp_tgt, vecs[i].exp_ill, vecs[i].exp_mis});
      #1 chk($sformatf("v%0d_br_unsigned", i), W'(br_unsigned), W'(vecs[i].exp_uns));
      @(negedge clk);
      ex_valid = 1'b0;
      s = sbq.pop_front();
      exp_bc = sat(exp_bc + 1);
      if (s.sel) begin
        exp_tc = sat(exp_tc + 1);
        last_tgt = s.tgt;
      end
      chk($sformatf("v%0d_pc_sel", i), W'(pc_sel), W'(s.sel));
      chk($sformatf("v%0d_pc_target", i), pc_target, last_tgt);
      chk($sformatf("v%0d_illegal", i), W'(illegal_br), W'(s.ill));
      chk($sformatf("v%0d_misaligned", i), W'(misaligned), W'(s.mis));
      chk($sformatf("v%0d_flush", i), W'(flush), W'(s.sel));
      chk_counts($sformatf("v%0d", i));
      if (s.sel) begin
        @(negedge clk);
        chk($sformatf("v%0d_flush2", i), W'(flush), 1);
        chk($sformatf("v%0d_pc_sel_pulse", i), W'(pc_sel), 0);
        @(negedge clk);
        chk($sformatf("v%0d_flush_end", i), W'(flush), 0);
      end else begin
        @(negedge clk);
        chk($sformatf("v%0d_pulse_clear", i), W'(illegal_br), 0);
      end
    end

    // Stall in RUN holds the redirect until EX is released.
    v = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h300, 32'h10, '0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h310, 1'b0, 1'b0};
    @(negedge clk);
    drive(v);
    ex_valid = 1'b1; stall = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("run_stall_pc_sel", W'(pc_sel), 0);
      chk("run_stall_flush", W'(flush), 0);
      chk_counts("run_stall");
    end
    stall = 1'b0;
    @(negedge clk);
    ex_valid = 1'b0;
    exp_bc = sat(exp_bc + 1); exp_tc = sat(exp_tc + 1);
    chk("run_stall_release_sel", W'(pc_sel), 1);
    chk("run_stall_release_tgt", pc_target, 32'h310);
    chk_counts("run_stall_release");
    wait_flush_clear();

    // Stall during FLUSH stretches the window; wrong-path EX is ignored.
    v = '{1'b0, 1'b1, 1'b0, 3'b000, 32'h500, 32'h4, '0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h504, 1'b0, 1'b0};
    @(negedge clk);
    drive(v);
    ex_valid = 1'b1;
    @(negedge clk);
    exp_bc = sat(exp_bc + 1); exp_tc = sat(exp_tc + 1);
    chk("fl_stall_pc_sel", W'(pc_sel), 1);
    chk("fl_stall_tgt", pc_target, 32'h504);
    fcount = 0;
    for (int c = 0; c < 20; c++) begin
      if (!flush) break;
      fcount++;
      stall = (fcount <= 3);
      ex_valid = 1'b1;
      @(negedge clk);
    end
    ex_valid = 1'b0; stall = 1'b0;
    chk("fl_stall_len", W'(fcount), 5);
    chk("fl_stall_pc_sel_after", W'(pc_sel), 0);
    chk_counts("fl_stall");

    // Reset on the 2nd flush cycle aborts the window.
    v = '{1'b0, 1'b1, 1'b0, 3'b000, 32'h600, 32'h8, '0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h608, 1'b0, 1'b0};
    @(negedge clk);
    drive(v);
    ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("mid_rst_flush1", W'(flush), 1);
    @(negedge clk);
    chk("mid_rst_flush2", W'(flush), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_bc = 0; exp_tc = 0;
    chk("mid_rst_flush", W'(flush), 0);
    chk("mid_rst_pc_sel", W'(pc_sel), 0);
    chk("mid_rst_tgt", pc_target, 0);
    chk_counts("mid_rst");
    drive(vecs[0]);
    ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    exp_bc = 1; exp_tc = 1;
    chk("post_rst_run_sel", W'(pc_sel), 1);
    chk("post_rst_run_tgt", pc_target, 32'h120);
    wait_flush_clear();

    // Counter saturation.
    for (int k = 0; k < 260; k++) do_jal(32'h1000, 32'h20);
    chk("sat_taken", W'(taken_cnt), 32'hFF);
    chk("sat_branch", W'(branch_cnt), 32'hFF);
    @(negedge clk);
    drive(vecs[9]);
    ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("sat_branch_hold", W'(branch_cnt), 32'hFF);
    chk("sat_nottaken_sel", W'(pc_sel), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
